// File: rtl/oup_ulpi_phy_sm.sv
// PHY-side ULPI synchronous-mode state machine: answers link TX CMDs, owns dir/nxt,
// serves a small register file and bridges line-side transmit/receive traffic.
module oup_ulpi_phy_sm #(
   parameter int         REG_COUNT  = 16,
   parameter logic [7:0] REG0_RESET = 8'h24
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_dir_o,
   input  logic       ulpi_stp_i,
   output logic       ulpi_nxt_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   output logic [3:0] tx_pid_o,
   input  logic       tx_ready_i,
   output logic       tx_done_o,
   input  logic       rx_active_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   input  logic [1:0] linestate_i,
   output logic       reg_wr_o,
   output logic [5:0] reg_addr_o,
   output logic [7:0] reg_wdata_o
);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_WR_CMD  = 4'd1;
   localparam logic [3:0] S_WR_DATA = 4'd2;
   localparam logic [3:0] S_WR_STP  = 4'd3;
   localparam logic [3:0] S_RD_CMD  = 4'd4;
   localparam logic [3:0] S_RD_TA   = 4'd5;
   localparam logic [3:0] S_RD_DATA = 4'd6;
   localparam logic [3:0] S_TX_CMD  = 4'd7;
   localparam logic [3:0] S_TX_DATA = 4'd8;
   localparam logic [3:0] S_RX      = 4'd9;
   localparam logic [3:0] S_RX_LAST = 4'd10;
   localparam logic [3:0] S_LS_TA   = 4'd11;
   localparam logic [3:0] S_TA_OUT  = 4'd12;

   logic [3:0] r_state;
   logic [5:0] r_addr;
   logic [7:0] r_wbyte;
   logic       r_rx_prev, r_rx_pend, r_ls_pend;
   logic [1:0] r_ls_prev;
   logic [7:0] r_data_o, r_tx_data, r_reg_wdata;
   logic       r_dir, r_nxt, r_tx_valid, r_tx_done, r_reg_wr;
   logic [3:0] r_tx_pid;
   logic [5:0] r_reg_addr;
   logic [7:0] r_regs [REG_COUNT];

   logic       w_rx_rise, w_ls_chg, w_rx_start;
   logic [1:0] w_cmd_op;
   logic [7:0] w_rxcmd, w_rd_data;

   assign w_rx_rise  = rx_active_i & ~r_rx_prev;
   assign w_ls_chg   = (linestate_i != r_ls_prev);
   assign w_rx_start = rx_active_i & (w_rx_rise | r_rx_pend);
   assign w_cmd_op   = ulpi_data_i[7:6];
   assign w_rxcmd    = {3'b000, rx_active_i, 2'b00, linestate_i};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_rd_data = 8'h00;
      for (int i = 0; i < REG_COUNT; i++)
         if (r_addr == 6'(i)) w_rd_data = r_regs[i];
   end

   // NOTE: sequential state uses non-blocking assignments only; the register file
   // is reset along with the FSM because software expects the reset values back.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wbyte     <= '0;
         r_rx_prev   <= 1'b0;
         r_rx_pend   <= 1'b0;
         r_ls_prev   <= '0;
         r_ls_pend   <= 1'b0;
         r_data_o    <= '0;
         r_dir       <= 1'b0;
         r_nxt       <= 1'b0;
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_pid    <= '0;
         r_tx_done   <= 1'b0;
         r_reg_wr    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         for (int i = 0; i < REG_COUNT; i++)
            r_regs[i] <= (i == 0) ? REG0_RESET : 8'h00;
      end else begin
         r_rx_prev  <= rx_active_i;
         r_ls_prev  <= linestate_i;
         r_tx_valid <= 1'b0;
         r_tx_done  <= 1'b0;
         r_reg_wr   <= 1'b0;
         // Events arriving mid-operation are remembered and serviced from IDLE.
         if (w_rx_rise && r_state != S_IDLE) r_rx_pend <= 1'b1;
         if (w_ls_chg && r_state != S_IDLE) r_ls_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_rx_pend <= 1'b0;
               if (w_rx_start) begin
                  r_dir    <= 1'b1;
                  r_nxt    <= 1'b1;
                  r_data_o <= 8'h00;
                  r_state  <= S_RX;
               end else if (r_ls_pend || (w_ls_chg && w_cmd_op == 2'b00 && !rx_active_i)) begin
                  r_ls_pend <= 1'b0;
                  r_dir     <= 1'b1;
                  r_nxt     <= 1'b0;
                  r_data_o  <= 8'h00;
                  r_state   <= S_LS_TA;
               end else begin
                  if (w_ls_chg) r_ls_pend <= 1'b1;
                  r_addr <= ulpi_data_i[5:0];
                  case (w_cmd_op)
                     2'b01: begin
                        r_tx_pid <= ulpi_data_i[3:0];
                        r_nxt    <= tx_ready_i;
                        r_state  <= S_TX_CMD;
                     end
                     2'b10: begin
                        r_nxt   <= 1'b1;
                        r_state <= S_WR_CMD;
                     end
                     2'b11: begin
                        r_nxt   <= 1'b1;
                        r_state <= S_RD_CMD;
                     end
                     default: ;
                  endcase
               end
            end
            S_WR_CMD: begin
               if (ulpi_stp_i) begin
                  r_nxt   <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               r_nxt <= 1'b0;
               if (ulpi_stp_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wbyte <= ulpi_data_i;
                  r_state <= S_WR_STP;
               end
            end
            S_WR_STP: begin
               if (ulpi_stp_i) begin
                  r_reg_wr    <= 1'b1;
                  r_reg_addr  <= r_addr;
                  r_reg_wdata <= r_wbyte;
                  for (int i = 0; i < REG_COUNT; i++)
                     if (r_addr == 6'(i)) r_regs[i] <= r_wbyte;
                  r_state <= S_IDLE;
               end
            end
            S_RD_CMD: begin
               r_nxt    <= 1'b0;
               r_dir    <= 1'b1;
               r_data_o <= 8'h00;
               r_state  <= S_RD_TA;
            end
            S_RD_TA: begin
               r_data_o <= w_rd_data;
               r_state  <= S_RD_DATA;
            end
            S_RD_DATA: begin
               r_dir    <= 1'b0;
               r_data_o <= 8'h00;
               r_state  <= S_TA_OUT;
            end
            S_TX_CMD: begin
               // Receive may still pre-empt a TX CMD that has not been acknowledged.
               if (!r_nxt && w_rx_rise) begin
                  r_rx_pend <= 1'b0;
                  r_dir     <= 1'b1;
                  r_nxt     <= 1'b1;
                  r_data_o  <= 8'h00;
                  r_state   <= S_RX;
               end else begin
                  r_nxt <= tx_ready_i;
                  if (r_nxt) r_state <= S_TX_DATA;
               end
            end
            S_TX_DATA: begin
               if (ulpi_stp_i) begin
                  r_tx_done <= 1'b1;
                  r_nxt     <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  if (r_nxt) begin
                     r_tx_data  <= ulpi_data_i;
                     r_tx_valid <= 1'b1;
                  end
                  r_nxt <= tx_ready_i;
               end
            end
            S_RX: begin
               if (rx_active_i && rx_valid_i) begin
                  r_data_o <= rx_data_i;
                  r_nxt    <= 1'b1;
               end else begin
                  r_data_o <= w_rxcmd;
                  r_nxt    <= 1'b0;
                  if (!rx_active_i) r_state <= S_RX_LAST;
               end
            end
            S_LS_TA: begin
               r_data_o <= w_rxcmd;
               r_state  <= S_RX_LAST;
            end
            S_RX_LAST: begin
               r_dir    <= 1'b0;
               r_nxt    <= 1'b0;
               r_data_o <= 8'h00;
               r_state  <= S_TA_OUT;
            end
            S_TA_OUT: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign ulpi_data_o = r_data_o;
   assign ulpi_dir_o  = r_dir;
   assign ulpi_nxt_o  = r_nxt;
   assign tx_data_o   = r_tx_data;
   assign tx_valid_o  = r_tx_valid;
   assign tx_pid_o    = r_tx_pid;
   assign tx_done_o   = r_tx_done;
   assign reg_wr_o    = r_reg_wr;
   assign reg_addr_o  = r_reg_addr;
   assign reg_wdata_o = r_reg_wdata;
endmodule
